// File: rtl/chain_frame_ctrl.sv
// Frame sequencer between the UART byte receiver and the chain-code decoder:
// sync hunt, 5-byte shape header, payload forwarding and one result per frame.
module chain_frame_ctrl #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned GAP_MAX     = 50000,
    parameter int unsigned DEC_TIMEOUT = 4096,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        dec_done,
    input  logic        dec_error,
    output logic        dec_rst,
    output logic        dec_start,
    output logic [6:0]  start_row,
    output logic [6:0]  start_col,
    output logic [7:0]  perimeter,
    output logic [11:0] area,
    output logic [7:0]  code,
    output logic        code_valid,
    output logic        busy,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [2:0]  err_code
);
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_START, S_PAYLOAD, S_WAIT, S_REPORT} state_t;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_HDR    = 3'd1;
    localparam logic [2:0] ERR_GAP    = 3'd2;
    localparam logic [2:0] ERR_DEC_TO = 3'd3;
    localparam logic [2:0] ERR_DEC    = 3'd4;

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_MAX - 1);
    localparam logic [CNT_W-1:0] DEC_LAST = CNT_W'(DEC_TIMEOUT - 1);

    state_t           state, state_nx;
    logic [2:0]       hdr_idx;
    logic [6:0]       pay_cnt, pay_cnt_inc, n_bytes;
    logic [CNT_W-1:0] timer;
    logic [7:0]       row_b, col_b;
    logic [7:0]       skid_data;
    logic             skid_vld;
    logic             fwd, hdr_bad, res_ok;
    logic [7:0]       fwd_data;
    logic [2:0]       res_err;

    logic             dec_rst_d, dec_start_d, code_valid_d, busy_d, frame_ok_d, frame_err_d;
    logic [7:0]       code_d;
    logic [2:0]       err_code_d;

    // Full header bytes are kept so the range check can see bits 7:6.
    assign start_row   = row_b[6:0];
    assign start_col   = col_b[6:0];
    assign n_bytes     = 7'((10'(perimeter) * 10'd3 + 10'd7) >> 3);
    assign pay_cnt_inc = pay_cnt + 7'd1;
    assign hdr_bad     = (row_b[7:6] != 2'b00) || (col_b[7:6] != 2'b00) || (perimeter == 8'd0);
    assign fwd         = (state == S_PAYLOAD) && (rx_valid || skid_vld);
    assign fwd_data    = skid_vld ? skid_data : rx_data;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        res_ok   = 1'b0;
        res_err  = ERR_NONE;
        case (state)
            S_IDLE: if (rx_valid && rx_data == SYNC_BYTE) state_nx = S_HDR;
            S_HDR: begin
                if (rx_valid) begin
                    if (hdr_idx == 3'd4) begin
                        if (hdr_bad) begin
                            state_nx = S_REPORT;
                            res_err  = ERR_HDR;
                        end else begin
                            state_nx = S_START;
                        end
                    end
                end else if (timer == GAP_LAST) begin
                    state_nx = S_REPORT;
                    res_err  = ERR_GAP;
                end
            end
            S_START: state_nx = S_PAYLOAD;
            S_PAYLOAD: begin
                if (fwd) begin
                    if (pay_cnt_inc == n_bytes) state_nx = S_WAIT;
                end else if (timer == GAP_LAST) begin
                    state_nx = S_REPORT;
                    res_err  = ERR_GAP;
                end
            end
            S_WAIT: begin
                if (dec_done) begin
                    state_nx = S_REPORT;
                    if (dec_error) res_err = ERR_DEC;
                    else           res_ok  = 1'b1;
                end else if (timer == DEC_LAST) begin
                    state_nx = S_REPORT;
                    res_err  = ERR_DEC_TO;
                end
            end
            S_REPORT: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so every pulse lines up with its state.
    always_comb begin
        dec_rst_d    = (state == S_IDLE) && (state_nx == S_HDR);
        dec_start_d  = (state_nx == S_START);
        code_valid_d = fwd;
        code_d       = fwd ? fwd_data : code;
        busy_d       = (state_nx != S_IDLE);
        frame_ok_d   = res_ok;
        frame_err_d  = (res_err != ERR_NONE);
        err_code_d   = err_code;
        if (dec_rst_d)                 err_code_d = ERR_NONE;
        else if (state_nx == S_REPORT) err_code_d = res_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dec_rst    <= 1'b0;
            dec_start  <= 1'b0;
            code       <= '0;
            code_valid <= 1'b0;
            busy       <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= '0;
        end else begin
            dec_rst    <= dec_rst_d;
            dec_start  <= dec_start_d;
            code       <= code_d;
            code_valid <= code_valid_d;
            busy       <= busy_d;
            frame_ok   <= frame_ok_d;
            frame_err  <= frame_err_d;
            err_code   <= err_code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_idx   <= '0;
            pay_cnt   <= '0;
            timer     <= '0;
            row_b     <= '0;
            col_b     <= '0;
            perimeter <= '0;
            area      <= '0;
            skid_data <= '0;
            skid_vld  <= 1'b0;
        end else begin
            if (state == S_HDR && rx_valid) hdr_idx <= hdr_idx + 3'd1;
            else if (state != S_HDR)        hdr_idx <= '0;

            if (state_nx == S_START) pay_cnt <= '0;
            else if (fwd)            pay_cnt <= pay_cnt_inc;

            // One counter serves as rx gap timer and decoder timeout; any state change restarts it.
            if (state_nx != state)
                timer <= '0;
            else if ((state == S_HDR || state == S_PAYLOAD) && (rx_valid || skid_vld))
                timer <= '0;
            else if (state == S_HDR || state == S_PAYLOAD || state == S_WAIT)
                timer <= timer + CNT_W'(1);

            if (state == S_HDR && rx_valid) begin
                case (hdr_idx)
                    3'd0:    row_b      <= rx_data;
                    3'd1:    col_b      <= rx_data;
                    3'd2:    perimeter  <= rx_data;
                    3'd3:    area[7:0]  <= rx_data;
                    3'd4:    area[11:8] <= rx_data[3:0];
                    default: ;
                endcase
            end

            if (state == S_START && rx_valid) begin
                skid_data <= rx_data;
                skid_vld  <= 1'b1;
            end else if (state == S_PAYLOAD) begin
                skid_vld  <= 1'b0;
            end
        end
    end
endmodule
